cla_addsub_mc: RTL and testbench
================================

Name: cla_addsub_mc

Overview:
- Parametrised multi-cycle adder/subtractor built from BLOCK-bit carry-lookahead slices.
- Resolves one slice per clock, LSB slice first, with the inter-slice carry held in a register.
- Trades latency for a short critical path in the wide datapaths of the processor (ALU extension, address/offset arithmetic).
- Start/busy/done handshake; result, carry-out and signed overflow are held until the next operation completes.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer multiple of BLOCK.
- BLOCK, 8, width of one lookahead slice resolved per cycle; 1 <= BLOCK <= WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0 = a+b+cin; 1 = a-b (a + ~b + 1), cin ignored.
- cin  input  1  carry-in for add mode.
- a  input  WIDTH  operand A, sampled at accept.
- b  input  WIDTH  operand B, sampled at accept.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: result valid.
- result  output  WIDTH  sum/difference.
- cout  output  1  carry out of MSB (sub: 1 = no borrow).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset values: busy=0, done=0, result=0, cout=0, ovf=0; FSM in IDLE; slice counter 0; carry register 0.
- N = WIDTH/BLOCK. FSM states: IDLE, RUN.
- IDLE: at a clock edge with start=1, the block accepts.
  - Latches a, and either b (add) or ~b (sub).
  - Latches the carry register as cin (add) or 1 (sub).
  - Clears the slice counter k, then moves to RUN with busy=1.
- RUN: each edge computes slice k = bits [k*BLOCK +: BLOCK] with full lookahead.
  - Generate g=a&b and propagate p=a|b per bit; carries are the OR of AND-terms over the carry register.
  - The slice sum goes to an internal accumulator; the carry register takes the slice carry-out; k increments.
  - On the edge computing k=N-1:
    - result <= full accumulator including the final slice; cout <= slice carry-out; ovf <= c[MSB] ^ cout.
    - done <= 1 and busy <= 0; return to IDLE.
- Latency: accept at edge E0, done high in the cycle after edge EN (N edges later). WIDTH=32, BLOCK=8 gives 4 cycles.
- done is high for exactly one cycle; result, cout and ovf hold until the next completion. No partial results appear on the outputs.
- start while busy=1 is ignored, with no queuing.
- start in the done cycle (busy=0) is accepted, giving back-to-back throughput of one op per N+1 cycles.
- a, b, sub and cin may change after accept without effect.
- N=1 (BLOCK=WIDTH): single RUN cycle, fully combinational lookahead.
- reset mid-operation aborts immediately; all outputs return to reset values and the in-flight op is lost.
- Counter width is clog2(N), minimum 1 bit; it wraps only via the return to IDLE.

Optional Feature:
- Macro CLA_SAT_EN.
- Defined: saturating signed result. At completion, if ovf=1, result is set to the signed limit instead of the wrapped sum:
  - 0111...1 when operand A's MSB = 0 (positive overflow);
  - 1000...0 when A's MSB = 1 (negative overflow).
  - ovf is still reported; cout is unchanged.
- Not defined: result is always the wrapped modulo-2^WIDTH value.

Test Plan:
- WIDTH=32, BLOCK=8: start with a=0x000000FF, b=0x00000001, sub=0, cin=0 -> done after 4 cycles; result=0x00000100, cout=0, ovf=0. Carry ripples across the slice 0 to slice 1 boundary.
- a=0xFFFFFFFF, b=0x00000000, cin=1 -> result=0x00000000, cout=1, ovf=0. Carry propagates through all 4 slices.
- sub=1, a=5, b=7 -> result=0xFFFFFFFE, cout=0, ovf=0. Then a=0x80000000, b=1 (sub) -> result=0x7FFFFFFF, ovf=1 (with CLA_SAT_EN: result=0x80000000, ovf=1).
- add a=0x7FFFFFFF, b=1 -> ovf=1, result=0x80000000 (with CLA_SAT_EN: 0x7FFFFFFF). Pulse start again mid-op -> ignored, single done.
- Hold start high continuously with changing operands -> accepts on every done cycle; done pulses every 5 cycles; each result matches the operands latched at its own accept.
- Assert reset during the 2nd RUN cycle -> busy=0, done=0, result=0 asynchronously. After release, a fresh op (a=3, b=4) gives result=7 with no stale carry. Repeat the cases with BLOCK=32 (N=1) and BLOCK=4 (N=8) against a reference model.

Source files
------------

// File: rtl/cla_addsub_mc_if.sv
// Operand/result bundle for the multi-cycle carry-lookahead adder/subtractor.
interface cla_addsub_mc_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/cla_addsub_mc.sv
// Multi-cycle adder/subtractor resolving one BLOCK-bit lookahead slice per clock, LSB first.
// Optional CLA_SAT_EN: saturate the result to the signed limit on overflow.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last completed result
// RUN   | resolving slice k, inter-slice carry held in a register
module cla_addsub_mc #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic            clock,
  input  logic            reset,
  cla_addsub_mc_if.slave  bus
);
  localparam int N  = WIDTH / BLOCK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] op_a, op_b, acc, acc_nxt, sum_ext, res_fin;
  logic             carry;
  logic [BLOCK-1:0] sa, sb, g, p, s;
  logic [BLOCK:0]   c;
  logic             prod, cterm;
  logic             last, accept, ovf_nxt;

  assign last     = (k == KW'(N - 1));
  assign accept   = (state == IDLE) && bus.start;
  assign bus.busy = (state == RUN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Each carry is a flat OR of generate/propagate product terms rooted at the slice carry-in.
  always_comb begin
    sa    = BLOCK'(op_a >> (k * BLOCK));
    sb    = BLOCK'(op_b >> (k * BLOCK));
    g     = sa & sb;
    p     = sa | sb;
    c     = '0;
    c[0]  = carry;
    prod  = 1'b0;
    cterm = 1'b0;
    for (int i = 0; i < BLOCK; i++) begin
      prod = carry;
      for (int m = 0; m <= i; m++) prod = prod & p[m];
      cterm = prod;
      for (int j = 0; j <= i; j++) begin
        prod = g[j];
        for (int m = j + 1; m <= i; m++) prod = prod & p[m];
        cterm = cterm | prod;
      end
      c[i+1] = cterm;
    end
    s       = sa ^ sb ^ c[BLOCK-1:0];
    sum_ext = '0;
    sum_ext[BLOCK-1:0] = s;
    acc_nxt = acc | (sum_ext << (k * BLOCK));
    ovf_nxt = c[BLOCK] ^ c[BLOCK-1];
    res_fin = acc_nxt;
`ifdef CLA_SAT_EN
    if (ovf_nxt) begin
      res_fin            = {WIDTH{~op_a[WIDTH-1]}};
      res_fin[WIDTH-1]   = op_a[WIDTH-1];
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_a       <= '0;
      op_b       <= '0;
      acc        <= '0;
      carry      <= 1'b0;
      k          <= '0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.cout   <= 1'b0;
      bus.ovf    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        op_a  <= bus.a;
        op_b  <= bus.sub ? ~bus.b : bus.b;
        carry <= bus.sub | bus.cin;
        acc   <= '0;
        k     <= '0;
      end else if (state == RUN) begin
        acc   <= acc_nxt;
        carry <= c[BLOCK];
        k     <= last ? '0 : k + 1'b1;
        if (last) begin
          bus.result <= res_fin;
          bus.cout   <= c[BLOCK];
          bus.ovf    <= ovf_nxt;
          bus.done   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cla_addsub_mc.sv
// Bench for cla_addsub_mc: three instances (BLOCK 8, 32, 4) driven in lockstep against an arithmetic model.
module tb_cla_addsub_mc;
  localparam int W  = 32;
  localparam int NI = 3;
  localparam int NN   [NI] = '{4, 1, 8};
  localparam int BLKS [NI] = '{8, 32, 4};
`ifdef CLA_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  int           tests_run = 0, tests_failed = 0;

  always #5 clock = ~clock;

  cla_addsub_mc_if #(.WIDTH(W)) bus8 ();
  cla_addsub_mc_if #(.WIDTH(W)) bus32 ();
  cla_addsub_mc_if #(.WIDTH(W)) bus4 ();

  assign bus8.start  = start; assign bus8.sub  = sub; assign bus8.cin  = cin; assign bus8.a  = a; assign bus8.b  = b;
  assign bus32.start = start; assign bus32.sub = sub; assign bus32.cin = cin; assign bus32.a = a; assign bus32.b = b;
  assign bus4.start  = start; assign bus4.sub  = sub; assign bus4.cin  = cin; assign bus4.a  = a; assign bus4.b  = b;

  cla_addsub_mc #(.WIDTH(W), .BLOCK(8))  dut8  (.clock(clock), .reset(reset), .bus(bus8.slave));
  cla_addsub_mc #(.WIDTH(W), .BLOCK(32)) dut32 (.clock(clock), .reset(reset), .bus(bus32.slave));
  cla_addsub_mc #(.WIDTH(W), .BLOCK(4))  dut4  (.clock(clock), .reset(reset), .bus(bus4.slave));

  logic         busy_o [NI], done_o [NI], cout_o [NI], ovf_o [NI];
  logic [W-1:0] res_o  [NI];
  assign busy_o[0] = bus8.busy;  assign done_o[0] = bus8.done;  assign cout_o[0] = bus8.cout;  assign ovf_o[0] = bus8.ovf;  assign res_o[0] = bus8.result;
  assign busy_o[1] = bus32.busy; assign done_o[1] = bus32.done; assign cout_o[1] = bus32.cout; assign ovf_o[1] = bus32.ovf; assign res_o[1] = bus32.result;
  assign busy_o[2] = bus4.busy;  assign done_o[2] = bus4.done;  assign cout_o[2] = bus4.cout;  assign ovf_o[2] = bus4.ovf;  assign res_o[2] = bus4.result;

  // Reference: plain (W+1)-bit addition; overflow from operand/result signs.
  function automatic logic [W+1:0] model(input logic [W-1:0] ai, bi, input logic si, ci);
    logic [W-1:0] be, r;
    logic [W:0]   s;
    logic         o;
    be = si ? ~bi : bi;
    s  = {1'b0, ai} + {1'b0, be} + {{W{1'b0}}, (si | ci)};
    o  = (ai[W-1] == be[W-1]) && (s[W-1] != ai[W-1]);
    r  = s[W-1:0];
    if (SAT && o) r = ai[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return {o, s[W], r};
  endfunction

  int           lat [NI], ndone [NI];
  bit           hs_bad [NI];
  logic [W-1:0] o_res [NI], prev_res [NI];
  logic         o_cout [NI], o_ovf [NI];

  // Drives one operation into all instances and records what each one reports.
  task automatic run_op(input logic [W-1:0] ai, bi, input logic si, ci, input bit mid_start);
    @(negedge clock);
    for (int i = 0; i < NI; i++) begin
      lat[i] = 0; ndone[i] = 0; hs_bad[i] = 1'b0; prev_res[i] = res_o[i];
      o_res[i] = '0; o_cout[i] = 1'b0; o_ovf[i] = 1'b0;
    end
    a = ai; b = bi; sub = si; cin = ci; start = 1'b1;
    @(negedge clock);
    start = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clock);
      for (int i = 0; i < NI; i++) begin
        if (done_o[i] === 1'b1) begin
          ndone[i]++;
          if (lat[i] == 0) begin
            lat[i] = cyc; o_res[i] = res_o[i]; o_cout[i] = cout_o[i]; o_ovf[i] = ovf_o[i];
            if (busy_o[i] !== 1'b0) hs_bad[i] = 1'b1;
          end
        end else if (lat[i] == 0 && (busy_o[i] !== 1'b1 || res_o[i] !== prev_res[i])) begin
          hs_bad[i] = 1'b1;
        end
      end
      start = mid_start && (cyc == 1);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < NI; i++) begin
      tests_run++;
      if ({busy_o[i], done_o[i], cout_o[i], ovf_o[i], res_o[i]} !== {4'b0000, {W{1'b0}}}) begin
        tests_failed++;
        $display("FAIL reset_state blk%0d: got busy=%b done=%b cout=%b ovf=%b result=%h, expected all zero",
                 BLKS[i], busy_o[i], done_o[i], cout_o[i], ovf_o[i], res_o[i]);
      end
    end
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic         sub, cin;
    logic [W-1:0] r;
    logic         co, ov;
    bit           mid;
  } vec_t;

  task automatic test_directed;
    vec_t v [7];
    v[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
    v[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    v[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    v[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    v[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, 1'b1};
    v[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    v[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, SAT ? 32'h8000_0000 : 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    for (int t = 0; t < 7; t++) begin
      run_op(v[t].a, v[t].b, v[t].sub, v[t].cin, v[t].mid);
      for (int i = 0; i < NI; i++) begin
        tests_run++;
        if (lat[i] !== NN[i]) begin
          tests_failed++;
          $display("FAIL dir%0d_latency blk%0d: got %0d cycles, expected %0d", t, BLKS[i], lat[i], NN[i]);
        end
        tests_run++;
        if ({o_res[i], o_cout[i], o_ovf[i]} !== {v[t].r, v[t].co, v[t].ov}) begin
          tests_failed++;
          $display("FAIL dir%0d_result blk%0d: got %h cout=%b ovf=%b, expected %h cout=%b ovf=%b",
                   t, BLKS[i], o_res[i], o_cout[i], o_ovf[i], v[t].r, v[t].co, v[t].ov);
        end
        tests_run++;
        if (ndone[i] !== ((v[t].mid && NN[i] == 1) ? 2 : 1)) begin
          tests_failed++;
          $display("FAIL dir%0d_done_count blk%0d: got %0d pulses, expected %0d", t, BLKS[i], ndone[i],
                   (v[t].mid && NN[i] == 1) ? 2 : 1);
        end
        tests_run++;
        if (hs_bad[i] !== 1'b0) begin
          tests_failed++;
          $display("FAIL dir%0d_handshake blk%0d: busy/hold violation flagged=%b, expected 0", t, BLKS[i], hs_bad[i]);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] ai, bi;
    logic         si, ci;
    logic [W+1:0] e;
    for (int t = 0; t < 25; t++) begin
      ai = $urandom; bi = $urandom;
      si = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        1: bi = ~ai;
        2: bi = ai;
        default: ;
      endcase
      e = model(ai, bi, si, ci);
      run_op(ai, bi, si, ci, 1'b0);
      for (int i = 0; i < NI; i++) begin
        tests_run++;
        if ({o_res[i], o_cout[i], o_ovf[i]} !== {e[W-1:0], e[W], e[W+1]} || lat[i] !== NN[i]) begin
          tests_failed++;
          $display("FAIL rand%0d blk%0d: a=%h b=%h sub=%b cin=%b got %h/%b/%b lat %0d, expected %h/%b/%b lat %0d",
                   t, BLKS[i], ai, bi, si, ci, o_res[i], o_cout[i], o_ovf[i], lat[i],
                   e[W-1:0], e[W], e[W+1], NN[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W+1:0] expq [NI][$];
    logic [W+1:0] e;
    int           last_done [NI];
    bit           acc_next [NI];
    for (int i = 0; i < NI; i++) begin last_done[i] = -1; acc_next[i] = 1'b1; end
    @(negedge clock);
    for (int cyc = 0; cyc < 52; cyc++) begin
      for (int i = 0; i < NI; i++) begin
        if (done_o[i] === 1'b1) begin
          tests_run++;
          if (expq[i].size() == 0) begin
            tests_failed++;
            $display("FAIL b2b_unexpected_done blk%0d: got done at cycle %0d, expected none", BLKS[i], cyc);
          end else begin
            e = expq[i].pop_front();
            if ({res_o[i], cout_o[i], ovf_o[i]} !== {e[W-1:0], e[W], e[W+1]}) begin
              tests_failed++;
              $display("FAIL b2b_result blk%0d: got %h/%b/%b, expected %h/%b/%b",
                       BLKS[i], res_o[i], cout_o[i], ovf_o[i], e[W-1:0], e[W], e[W+1]);
            end
          end
          if (last_done[i] >= 0) begin
            tests_run++;
            if (cyc - last_done[i] !== NN[i] + 1) begin
              tests_failed++;
              $display("FAIL b2b_interval blk%0d: got %0d cycles, expected %0d", BLKS[i], cyc - last_done[i], NN[i] + 1);
            end
          end
          last_done[i] = cyc;
          acc_next[i]  = 1'b1;
        end
      end
      if (cyc < 40) begin
        a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
        start = 1'b1;
        for (int i = 0; i < NI; i++) begin
          if (acc_next[i]) begin expq[i].push_back(model(a, b, sub, cin)); acc_next[i] = 1'b0; end
        end
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    for (int i = 0; i < NI; i++) begin
      tests_run++;
      if (expq[i].size() !== 0) begin
        tests_failed++;
        $display("FAIL b2b_outstanding blk%0d: got %0d ops never completed, expected 0", BLKS[i], expq[i].size());
      end
    end
  endtask

  task automatic test_reset_abort;
    @(negedge clock);
    a = 32'hFFFF_FFFF; b = 32'h0; sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      tests_run++;
      if ({busy_o[i], done_o[i], cout_o[i], ovf_o[i], res_o[i]} !== {4'b0000, {W{1'b0}}}) begin
        tests_failed++;
        $display("FAIL abort_async blk%0d: got busy=%b done=%b cout=%b ovf=%b result=%h, expected all zero",
                 BLKS[i], busy_o[i], done_o[i], cout_o[i], ovf_o[i], res_o[i]);
      end
    end
    @(negedge clock);
    reset = 1'b0;
    run_op(32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NI; i++) begin
      tests_run++;
      if ({o_res[i], o_cout[i], o_ovf[i]} !== {32'd7, 1'b0, 1'b0} || lat[i] !== NN[i]) begin
        tests_failed++;
        $display("FAIL abort_fresh_op blk%0d: got %h/%b/%b lat %0d, expected 00000007/0/0 lat %0d",
                 BLKS[i], o_res[i], o_cout[i], o_ovf[i], lat[i], NN[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
